// File: rtl/down_timer_pkg.sv
// down_timer_pkg: state encoding and width helper shared by the down_timer files
package down_timer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;
    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/tff_cell.sv
// tff_cell: one counter bit as a T flip-flop with sync reset and parallel load
//   i_clk, i_rst : clock, sync active-high reset (clears o_q)
//   i_ld, i_d    : parallel load, takes priority over toggle
//   i_t          : toggle enable
//   o_q          : stored bit
module tff_cell (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ld,
    input  logic i_d,
    input  logic i_t,
    output logic o_q
);
    logic r_q;
    always_ff @(posedge i_clk)
        if (i_rst) r_q <= 1'b0;
        else if (i_ld) r_q <= i_d;
        else if (i_t) r_q <= ~r_q;
    assign o_q = r_q;
endmodule

// File: rtl/down_timer.sv
// down_timer: loadable prescaled down-counting timer with terminal-count pulse and auto-reload
//   i_sysclk, i_reset          : clock, sync active-high reset
//   i_load, i_load_value       : capture start/reload value
//   i_start, i_stop            : begin/restart counting, abort and hold
//   i_auto_reload              : reload on terminal count instead of stopping
//   i_clear_flag               : clear sticky o_expired
//   o_count, o_busy            : current count, state is RUN
//   o_tc_pulse, o_expired      : 1-cycle terminal-count pulse, sticky expired flag
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             i_sysclk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_auto_reload,
    input  logic             i_clear_flag,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_tc_pulse,
    output logic             o_expired
);
    localparam int PW = clog2(PRESCALE);
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);
    state_t           r_state, w_next;
    logic [PW-1:0]    r_psc;
    logic [WIDTH-1:0] r_reload, r_count, w_d, w_t;
    logic             r_tc, r_exp, w_ld, w_rl_ld, w_tc, w_tick, w_dec, w_enter;
    assign w_tick  = r_psc == '0;
    assign w_dec   = (r_state == ST_RUN) && !i_stop && w_tick;
    assign w_enter = (w_next == ST_RUN) && (r_state != ST_RUN);
    always_comb begin
        w_next  = r_state;
        w_ld    = 1'b0;
        w_d     = i_load_value;
        w_rl_ld = 1'b0;
        w_tc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ld    = i_load;
                w_rl_ld = i_load;
                if (i_start && ((i_load ? i_load_value : r_count) != '0)) w_next = ST_RUN;
            end
            ST_RUN: begin
                w_rl_ld = i_load;
                if (i_stop) w_next = ST_IDLE;
                else if (w_tick && r_count == WIDTH'(1)) begin
                    // Terminal count: the toggle chain is overridden by a parallel load.
                    w_tc = 1'b1;
                    w_ld = 1'b1;
                    if (i_auto_reload && r_reload != '0) w_d = r_reload;
                    else begin
                        w_d    = '0;
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (i_load) begin
                    w_ld    = 1'b1;
                    w_rl_ld = 1'b1;
                    w_next  = (i_start && i_load_value != '0) ? ST_RUN : ST_IDLE;
                end else if (i_start) begin
                    w_ld   = 1'b1;
                    w_d    = r_reload;
                    w_next = (r_reload != '0) ? ST_RUN : ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge i_sysclk)
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_reload <= '0;
            r_psc    <= '0;
            r_tc     <= 1'b0;
            r_exp    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_rl_ld) r_reload <= i_load_value;
            if (w_enter) r_psc <= PS_MAX;
            else if (r_state == ST_RUN) r_psc <= w_tick ? PS_MAX : r_psc - PW'(1);
            r_tc  <= w_tc;
            r_exp <= w_tc | (r_exp & ~i_clear_flag);
        end
    // Bit i toggles on a decrement when every lower bit is zero (borrow ripple).
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign w_t[i] = w_dec;
        end else begin : g_upper
            assign w_t[i] = w_dec & ~|r_count[i-1:0];
        end
        tff_cell u_tff (
            .i_clk(i_sysclk),
            .i_rst(i_reset),
            .i_ld (w_ld),
            .i_d  (w_d[i]),
            .i_t  (w_t[i]),
            .o_q  (r_count[i])
        );
    end
    assign o_count    = r_count;
    assign o_busy     = r_state == ST_RUN;
    assign o_tc_pulse = r_tc;
    assign o_expired  = r_exp;
endmodule
